// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: sequencer control, gate stimulus/response and result bus
// master: drives start and the gate response dut_out; observes the vector and results.
// slave : the checker; drives dut_in, busy, done, pass, err_count, fail_seen, first_fail.
interface truth_table_checker_if #(parameter int N_IN = 2);
  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_seen;
  logic [N_IN-1:0] first_fail;
  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_count, fail_seen, first_fail
  );
  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_count, fail_seen, first_fail
  );
endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector of a gate and checks it against TRUTH
// Ports: clk (rising edge), reset (sync, active high), bus (truth_table_checker_if.slave):
//   start in, dut_out in, dut_in out, busy out, done out, pass out,
//   err_count out, fail_seen out, first_fail out.
// Option: define TTC_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module truth_table_checker #(
  parameter int                 N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 4'b1000,
  parameter int                 SETTLE = 10
) (
  input logic                 clk,
  input logic                 reset,
  truth_table_checker_if.slave bus
);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_idx, r_first_fail;
  logic [N_IN:0]   r_err_count;
  logic            r_fail_seen;
  logic            w_go, w_mis, w_last, w_stop;
  assign w_go   = (r_state == IDLE || r_state == DONE) && bus.start;
  assign w_mis  = r_state == SAMPLE && bus.dut_out != TRUTH[r_idx];
  assign w_last = &r_idx;
`ifdef TTC_STOP_ON_FAIL_EN
  assign w_stop = w_last || w_mis;
`else
  assign w_stop = w_last;
`endif
  always_comb begin
    w_next = r_state;
    if (w_go) w_next = DRIVE;
    else if (r_state == DRIVE) w_next = r_cnt == '0 ? SAMPLE : DRIVE;
    else if (r_state == SAMPLE) w_next = w_stop ? DONE : DRIVE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // dut_in is r_idx itself, so the vector cannot drift from the index being checked
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_err_count  <= '0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= '0;
    end else if (w_go) begin
      r_cnt        <= CW'(SETTLE - 1);
      r_idx        <= '0;
      r_err_count  <= '0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= '0;
    end else if (r_state == DRIVE && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end else if (r_state == SAMPLE) begin
      if (w_mis) begin
        r_err_count <= r_err_count + (N_IN+1)'(1);
        if (!r_fail_seen) begin
          r_fail_seen  <= 1'b1;
          r_first_fail <= r_idx;
        end
      end
      if (!w_stop) begin
        r_idx <= r_idx + N_IN'(1);
        r_cnt <= CW'(SETTLE - 1);
      end
    end
  end
  assign bus.dut_in     = r_idx;
  assign bus.busy       = r_state == DRIVE || r_state == SAMPLE;
  assign bus.done       = r_state == DONE;
  assign bus.pass       = r_state == DONE && r_err_count == '0;
  assign bus.err_count  = r_err_count;
  assign bus.fail_seen  = r_fail_seen;
  assign bus.first_fail = r_first_fail;
endmodule
